// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - interval store and one-second countdown timer for the traffic-light FSM
module interval_timer_ctrl #(
    parameter int TICK_DIV     = 100_000_000,
    parameter int VAL_W        = 4,
    parameter int BASE_DEFAULT = 6,
    parameter int EXT_DEFAULT  = 3,
    parameter int YEL_DEFAULT  = 2
) (
    input  logic             clk,
    input  logic             sys_reset,
    input  logic             prg_sync_in,
    input  logic [1:0]       param_sel,
    input  logic [VAL_W-1:0] time_value,
    input  logic [1:0]       interval_address,
    input  logic             start_timer,
    output logic             expired,
    output logic [VAL_W-1:0] time_left,
    output logic             busy
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [VAL_W-1:0] BASE_DEF = VAL_W'(BASE_DEFAULT);
    localparam logic [VAL_W-1:0] EXT_DEF  = VAL_W'(EXT_DEFAULT);
    localparam logic [VAL_W-1:0] YEL_DEF  = VAL_W'(YEL_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [VAL_W-1:0] base_val;
    logic [VAL_W-1:0] ext_val;
    logic [VAL_W-1:0] yel_val;
    logic [VAL_W-1:0] load_val;

    assign tick = (div == DIV_LAST);

    // Address 11 falls through to the base interval.
    always_comb begin
        load_val = base_val;
        case (interval_address)
            2'b01:   load_val = ext_val;
            2'b10:   load_val = yel_val;
            default: load_val = base_val;
        endcase
    end

    // A zero write means "use the default", so no stored interval is ever 0.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            base_val <= BASE_DEF;
            ext_val  <= EXT_DEF;
            yel_val  <= YEL_DEF;
        end else if (prg_sync_in) begin
            case (param_sel)
                2'b00: base_val <= (time_value == '0) ? BASE_DEF : time_value;
                2'b01: ext_val  <= (time_value == '0) ? EXT_DEF  : time_value;
                2'b10: yel_val  <= (time_value == '0) ? YEL_DEF  : time_value;
                default: begin
                    base_val <= BASE_DEF;
                    ext_val  <= EXT_DEF;
                    yel_val  <= YEL_DEF;
                end
            endcase
        end
    end

    // start_timer reloads from every state, so it is handled ahead of the state case.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state     <= IDLE;
            expired   <= 1'b0;
            time_left <= '0;
            div       <= '0;
            busy      <= 1'b0;
        end else begin
            expired <= 1'b0;
            div     <= tick ? '0 : div + 1'b1;
            if (start_timer) begin
                state     <= RUN;
                busy      <= 1'b1;
                time_left <= load_val;
                div       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RUN: begin
                        if (tick) begin
                            if (time_left > VAL_W'(1)) begin
                                time_left <= time_left - 1'b1;
                            end else begin
                                time_left <= '0;
                                state     <= EXPIRE;
                                expired   <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end
                    end
                    EXPIRE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - scoreboard bench for interval_timer_ctrl
module tb_interval_timer_ctrl;

    localparam int TICK = 4;
    localparam int VW   = 4;

    logic          clk = 1'b0;
    logic          sys_reset = 1'b1;
    logic          prg_sync_in = 1'b0;
    logic [1:0]    param_sel = 2'b00;
    logic [VW-1:0] time_value = '0;
    logic [1:0]    interval_address = 2'b00;
    logic          start_timer = 1'b0;
    logic          expired;
    logic [VW-1:0] time_left;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int exp_q[$];
    int base_m = 6;
    int ext_m  = 3;
    int yel_m  = 2;
    bit prev_exp = 1'b0;

    interval_timer_ctrl #(
        .TICK_DIV(TICK),
        .VAL_W(VW),
        .BASE_DEFAULT(6),
        .EXT_DEFAULT(3),
        .YEL_DEFAULT(2)
    ) dut (
        .clk(clk),
        .sys_reset(sys_reset),
        .prg_sync_in(prg_sync_in),
        .param_sel(param_sel),
        .time_value(time_value),
        .interval_address(interval_address),
        .start_timer(start_timer),
        .expired(expired),
        .time_left(time_left),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every expired pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!sys_reset && expired) begin
            check("exp_width", int'(prev_exp), 0);
            if (exp_q.size() == 0)
                check("exp_unexpected", int'(expired), 0);
            else
                check("exp_cycle", edge_cnt, exp_q.pop_front());
        end
        prev_exp = expired;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int model_val(input logic [1:0] addr);
        case (addr)
            2'b01:   return ext_m;
            2'b10:   return yel_m;
            default: return base_m;
        endcase
    endfunction

    task automatic model_write(input logic [1:0] sel, input int val);
        case (sel)
            2'b00: base_m = (val == 0) ? 6 : val;
            2'b01: ext_m  = (val == 0) ? 3 : val;
            2'b10: yel_m  = (val == 0) ? 2 : val;
            default: begin
                base_m = 6;
                ext_m  = 3;
                yel_m  = 2;
            end
        endcase
    endtask

    task automatic do_write(input logic [1:0] sel, input int val);
        prg_sync_in = 1'b1;
        param_sel   = sel;
        time_value  = VW'(val);
        tick();
        prg_sync_in = 1'b0;
        model_write(sel, val);
    endtask

    // A restart abandons the pending expiry; load edge is the next posedge.
    task automatic push_load(input logic [1:0] addr, output int n);
        n = model_val(addr);
        if (busy && exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(edge_cnt + 1 + n * TICK);
        start_timer      = 1'b1;
        interval_address = addr;
    endtask

    task automatic start_load(input logic [1:0] addr, input string tag);
        int n;
        push_load(addr, n);
        tick();
        start_timer = 1'b0;
        check({tag, "_tl"}, int'(time_left), n);
        check({tag, "_busy"}, int'(busy), 1);
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_drained"}, int'(k < 200), 1);
    endtask

    task automatic do_reset();
        sys_reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        sys_reset = 1'b0;
        model_write(2'b11, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;

        // 1: reset state and base countdown
        do_reset();
        check("rst_expired", int'(expired), 0);
        check("rst_tl", int'(time_left), 0);
        check("rst_busy", int'(busy), 0);
        start_load(2'b00, "base");
        wait_drain("base");
        tick();
        check("idle_busy", int'(busy), 0);
        check("idle_tl", int'(time_left), 0);

        // 2: program yellow to 5
        do_write(2'b10, 5);
        start_load(2'b10, "yel5");
        wait_drain("yel5");

        // 3: zero write gives default, restore-all, address 11 is base
        do_write(2'b01, 0);
        start_load(2'b01, "ext0");
        wait_drain("ext0");
        do_write(2'b00, 9);
        do_write(2'b01, 7);
        do_write(2'b10, 1);
        start_load(2'b10, "yel1");
        wait_drain("yel1");
        do_write(2'b11, 4);
        start_load(2'b00, "def_base");
        start_load(2'b01, "def_ext");
        start_load(2'b10, "def_yel");
        wait_drain("defaults");
        do_write(2'b00, 5);
        start_load(2'b11, "addr3");
        wait_drain("addr3");

        // simultaneous write and load uses the old value
        prg_sync_in = 1'b1;
        param_sel   = 2'b00;
        time_value  = VW'(8);
        push_load(2'b00, n);
        tick();
        prg_sync_in = 1'b0;
        start_timer = 1'b0;
        model_write(2'b00, 8);
        check("simul_tl", int'(time_left), n);
        wait_drain("simul");
        start_load(2'b00, "after_simul");
        wait_drain("after_simul");

        // write during a countdown leaves the count alone
        start_load(2'b01, "mid_write");
        do_write(2'b01, 12);
        wait_drain("mid_write");
        do_write(2'b11, 0);

        // 4: restart at +10 cycles
        start_load(2'b00, "restart_a");
        repeat (9) tick();
        start_load(2'b00, "restart_b");
        wait_drain("restart");

        // 5: back-to-back reload in the EXPIRE cycle
        start_load(2'b10, "b2b_a");
        k = 0;
        while (!expired && k < 100) begin
            tick();
            k++;
        end
        check("b2b_seen", int'(expired), 1);
        start_load(2'b01, "b2b_b");
        wait_drain("b2b");

        // 6: reset mid-countdown restores defaults, no pulse
        do_write(2'b00, 9);
        start_load(2'b00, "rst_mid");
        k = 0;
        while (time_left != VW'(3) && k < 100) begin
            tick();
            k++;
        end
        check("rst_mid_tl3", int'(time_left), 3);
        sys_reset = 1'b1;
        exp_q.delete();
        tick();
        check("rst_mid_tl", int'(time_left), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_exp", int'(expired), 0);
        sys_reset = 1'b0;
        model_write(2'b11, 0);
        repeat (40) tick();
        start_load(2'b01, "post_rst_ext");
        start_load(2'b10, "post_rst_yel");
        start_load(2'b00, "post_rst_base");
        wait_drain("post_rst");

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
